// File: rtl/wbrd2axilm_pkg.sv
`default_nettype none
// ============================================================================
// wbrd2axilm_pkg : AXI response codes, AR protection default and bridge states
// Revision       : 1.0
// ============================================================================
package wbrd2axilm_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_FLUSH = 2'd2,
        S_WERR  = 2'd3
    } state_t;

    // SLVERR and DECERR both surface to the WB master as a bus error
    function automatic logic resp_is_err(input logic [1:0] resp);
        logic is_err;
        case (resp)
            AXI_RESP_OKAY:   is_err = 1'b0;
            AXI_RESP_EXOKAY: is_err = 1'b0;
            AXI_RESP_SLVERR: is_err = 1'b1;
            AXI_RESP_DECERR: is_err = 1'b1;
            default:         is_err = 1'b1;
        endcase
        return is_err;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wbrd2axilm_if.sv
`default_nettype none
// ============================================================================
// wbrd2axilm_if : WB slave read port plus AXI-lite AR/R master channels
// Revision      : 1.0
// ============================================================================
interface wbrd2axilm_if #(
    parameter int DW         = 32,
    parameter int ADDR_WIDTH = 28,
    parameter int AW         = ADDR_WIDTH - $clog2(DW/8)
);
    logic                  i_wb_cyc;
    logic                  i_wb_stb;
    logic                  i_wb_we;
    logic [AW-1:0]         i_wb_addr;
    logic [DW/8-1:0]       i_wb_sel;
    logic                  o_wb_stall;
    logic                  o_wb_ack;
    logic [DW-1:0]         o_wb_data;
    logic                  o_wb_err;

    logic                  o_axi_arvalid;
    logic                  i_axi_arready;
    logic [ADDR_WIDTH-1:0] o_axi_araddr;
    logic [2:0]            o_axi_arprot;
    logic                  i_axi_rvalid;
    logic                  o_axi_rready;
    logic [DW-1:0]         i_axi_rdata;
    logic [1:0]            i_axi_rresp;

    // Bridge side
    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_sel,
        output o_wb_stall, o_wb_ack, o_wb_data, o_wb_err,
        output o_axi_arvalid, o_axi_araddr, o_axi_arprot, o_axi_rready,
        input  i_axi_arready, i_axi_rvalid, i_axi_rdata, i_axi_rresp
    );

    // Environment side: WB master and AXI-lite slave
    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_sel,
        input  o_wb_stall, o_wb_ack, o_wb_data, o_wb_err,
        input  o_axi_arvalid, o_axi_araddr, o_axi_arprot, o_axi_rready,
        output i_axi_arready, i_axi_rvalid, i_axi_rdata, i_axi_rresp
    );

endinterface
`default_nettype wire

// File: rtl/wbrd2axilm.sv
`default_nettype none
// ============================================================================
// wbrd2axilm : pipelined WB read slave to AXI-lite AR/R master, writes errored
// Revision   : 1.0
// ============================================================================
module wbrd2axilm #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 28,
    parameter int LGFIFO           = 3
) (
    input  wire logic    i_clk,
    input  wire logic    w_reset,
    wbrd2axilm_if.slave  bus
);
    import wbrd2axilm_pkg::*;

    localparam int DW      = C_AXI_DATA_WIDTH;
    localparam int AXILLSB = $clog2(DW/8);
    localparam int AW      = C_AXI_ADDR_WIDTH - AXILLSB;

    localparam logic [LGFIFO:0] OUTSTANDING_MAX = {1'b1, {LGFIFO{1'b0}}};
    localparam logic [LGFIFO:0] OUTSTANDING_ONE = {{LGFIFO{1'b0}}, 1'b1};

    state_t                      state_q, state_d;
    logic [LGFIFO:0]             outstanding_q, outstanding_d;
    logic                        arvalid_q, arvalid_d;
    logic [C_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                        ack_q, ack_d;
    logic                        err_q, err_d;
    logic [DW-1:0]               data_q, data_d;

    logic w_stall;
    logic w_accept;
    logic w_rd_accept;
    logic w_wr_accept;
    logic w_r_beat;
    logic w_r_deliver;
    logic w_r_is_err;
    logic w_unused_ok;

    assign w_unused_ok = &{1'b0, bus.i_wb_sel};

    // A write is only taken once nothing is in flight, so its error can never
    // collide with a read response on the same cycle.
    always_comb begin
        w_stall = (arvalid_q && !bus.i_axi_arready)
               || (outstanding_q == OUTSTANDING_MAX)
               || (state_q == S_FLUSH)
               || (state_q == S_WERR)
               || (bus.i_wb_we && ((outstanding_q != '0) || arvalid_q));
    end

    always_comb begin
        w_accept    = bus.i_wb_cyc && bus.i_wb_stb && !w_stall;
        w_rd_accept = w_accept && !bus.i_wb_we;
        w_wr_accept = w_accept && bus.i_wb_we;
        w_r_beat    = bus.i_axi_rvalid && (outstanding_q != '0);
        w_r_deliver = w_r_beat && (state_q == S_READ) && bus.i_wb_cyc;
        w_r_is_err  = resp_is_err(bus.i_axi_rresp);
    end

    always_comb begin
        outstanding_d = outstanding_q;
        case ({w_rd_accept, w_r_beat})
            2'b10:   outstanding_d = outstanding_q + OUTSTANDING_ONE;
            2'b01:   outstanding_d = outstanding_q - OUTSTANDING_ONE;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // AR stays put while waiting for arready; stall prevents a new accept
    // from overwriting a request that has not been taken yet.
    always_comb begin
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        if (w_rd_accept) begin
            arvalid_d = 1'b1;
            araddr_d  = {bus.i_wb_addr[AW-1:0], {AXILLSB{1'b0}}};
        end else if (arvalid_q && bus.i_axi_arready) begin
            arvalid_d = 1'b0;
        end
    end

    always_comb begin
        ack_d  = w_r_deliver && !w_r_is_err;
        err_d  = (w_r_deliver && w_r_is_err) || w_wr_accept;
        data_d = data_q;
        if (w_r_deliver) begin
            data_d = bus.i_axi_rdata;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (w_wr_accept) begin
                    state_d = S_WERR;
                end else if (w_rd_accept) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (!bus.i_wb_cyc) begin
                    state_d = (outstanding_d == '0) ? S_IDLE : S_FLUSH;
                end else if (outstanding_d == '0) begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (outstanding_d == '0) begin
                    state_d = S_IDLE;
                end
            end
            S_WERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_reset) begin
            state_q       <= S_IDLE;
            outstanding_q <= '0;
            arvalid_q     <= 1'b0;
            araddr_q      <= '0;
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            data_q        <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            arvalid_q     <= arvalid_d;
            araddr_q      <= araddr_d;
            ack_q         <= ack_d;
            err_q         <= err_d;
            data_q        <= data_d;
        end
    end

    assign bus.o_wb_stall    = w_stall;
    assign bus.o_wb_ack      = ack_q;
    assign bus.o_wb_err      = err_q;
    assign bus.o_wb_data     = data_q;
    assign bus.o_axi_arvalid = arvalid_q;
    assign bus.o_axi_araddr  = araddr_q;
    assign bus.o_axi_arprot  = AXI_PROT_DEFAULT;
    assign bus.o_axi_rready  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_wbrd2axilm.sv
`default_nettype none
// ============================================================================
// tb_wbrd2axilm : directed scenarios plus randomized traffic against a queue model
// Revision      : 1.0
// ============================================================================
module tb_wbrd2axilm;
    import wbrd2axilm_pkg::*;

    localparam int DW         = 32;
    localparam int ADDR_WIDTH = 28;
    localparam int LGFIFO     = 3;
    localparam int AW         = ADDR_WIDTH - 2;
    localparam int DEPTH      = 1 << LGFIFO;

    logic i_clk = 1'b0;
    logic w_reset;
    int   checks   = 0;
    int   failures = 0;

    wbrd2axilm_if #(.DW(DW), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    wbrd2axilm #(
        .C_AXI_DATA_WIDTH(DW),
        .C_AXI_ADDR_WIDTH(ADDR_WIDTH),
        .LGFIFO(LGFIFO)
    ) dut (
        .i_clk(i_clk),
        .w_reset(w_reset),
        .bus(bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_wb_cyc      = 1'b0;
        bus.i_wb_stb      = 1'b0;
        bus.i_wb_we       = 1'b0;
        bus.i_wb_addr     = '0;
        bus.i_wb_sel      = '1;
        bus.i_axi_arready = 1'b1;
        bus.i_axi_rvalid  = 1'b0;
        bus.i_axi_rdata   = '0;
        bus.i_axi_rresp   = AXI_RESP_OKAY;
    endtask

    task automatic do_reset();
        idle_inputs();
        w_reset = 1'b1;
        tick();
        tick();
        w_reset = 1'b0;
    endtask

    // Stimulus only: one read through AR and R with arready high, observations returned.
    task automatic single_read(input logic [AW-1:0] addr, input logic [DW-1:0] d, input logic [1:0] resp,
                               output logic [ADDR_WIDTH-1:0] araddr, output logic ack, output logic err,
                               output logic [DW-1:0] data, output logic tail);
        bus.i_axi_arready = 1'b1;
        bus.i_wb_cyc  = 1'b1;
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_we   = 1'b0;
        bus.i_wb_addr = addr;
        tick();
        bus.i_wb_stb = 1'b0;
        araddr = bus.o_axi_araddr;
        tick();
        bus.i_axi_rvalid = 1'b1;
        bus.i_axi_rdata  = d;
        bus.i_axi_rresp  = resp;
        tick();
        ack  = bus.o_wb_ack;
        err  = bus.o_wb_err;
        data = bus.o_wb_data;
        bus.i_axi_rvalid = 1'b0;
        tick();
        tail = bus.o_wb_ack | bus.o_wb_err;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.o_wb_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%0b exp=0", bus.o_wb_ack); end
        checks++; if (bus.o_wb_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", bus.o_wb_err); end
        checks++; if (bus.o_wb_data !== '0) begin failures++; $display("FAIL reset_data got=%0h exp=0", bus.o_wb_data); end
        checks++; if (bus.o_axi_arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid got=%0b exp=0", bus.o_axi_arvalid); end
        checks++; if (bus.o_wb_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", bus.o_wb_stall); end
        checks++; if (bus.o_axi_arprot !== 3'b000) begin failures++; $display("FAIL reset_arprot got=%0b exp=000", bus.o_axi_arprot); end
        checks++; if (bus.o_axi_rready !== 1'b1) begin failures++; $display("FAIL reset_rready got=%0b exp=1", bus.o_axi_rready); end
    endtask

    task automatic test_single_read();
        logic [ADDR_WIDTH-1:0] araddr;
        logic ack, err, tail;
        logic [DW-1:0] data, d;
        logic [AW-1:0] a;
        single_read(26'h10, 32'hDEADBEEF, AXI_RESP_OKAY, araddr, ack, err, data, tail);
        checks++; if (araddr !== 28'h40) begin failures++; $display("FAIL single_araddr got=%0h exp=40", araddr); end
        checks++; if (ack !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL single_ack got=%0b/%0b exp=1/0", ack, err); end
        checks++; if (data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data got=%0h exp=deadbeef", data); end
        checks++; if (tail !== 1'b0) begin failures++; $display("FAIL single_pulse got=%0b exp=0", tail); end
        for (int i = 0; i < 3; i++) begin
            a = AW'($urandom);
            d = $urandom;
            single_read(a, d, AXI_RESP_EXOKAY, araddr, ack, err, data, tail);
            checks++; if (araddr !== ADDR_WIDTH'({a, 2'b00})) begin failures++; $display("FAIL rand_araddr got=%0h exp=%0h", araddr, {a, 2'b00}); end
            checks++; if (ack !== 1'b1 || err !== 1'b0 || data !== d) begin failures++; $display("FAIL rand_read got=%0b/%0b/%0h exp=1/0/%0h", ack, err, data, d); end
        end
    endtask

    task automatic test_fill_stall();
        logic [AW-1:0] addrs [9];
        logic [DW-1:0] d;
        int accepted = 0;
        int ar_seen  = 0;
        do_reset();
        for (int i = 0; i < 9; i++) addrs[i] = AW'($urandom);
        bus.i_wb_cyc = 1'b1;
        for (int c = 0; c < 12; c++) begin
            bus.i_wb_stb  = 1'b1;
            bus.i_wb_addr = addrs[accepted];
            #1;
            if (bus.o_axi_arvalid && bus.i_axi_arready) begin
                checks++; if (bus.o_axi_araddr !== ADDR_WIDTH'({addrs[ar_seen], 2'b00})) begin failures++; $display("FAIL fill_araddr%0d got=%0h exp=%0h", ar_seen, bus.o_axi_araddr, {addrs[ar_seen], 2'b00}); end
                ar_seen++;
            end
            if (!bus.o_wb_stall) accepted++;
            tick();
        end
        checks++; if (accepted !== DEPTH) begin failures++; $display("FAIL fill_accepted got=%0d exp=%0d", accepted, DEPTH); end
        checks++; if (ar_seen !== DEPTH) begin failures++; $display("FAIL fill_ar_count got=%0d exp=%0d", ar_seen, DEPTH); end
        checks++; if (bus.o_wb_stall !== 1'b1) begin failures++; $display("FAIL fill_stall9 got=%0b exp=1", bus.o_wb_stall); end
        d = $urandom;
        bus.i_axi_rvalid = 1'b1;
        bus.i_axi_rdata  = d;
        bus.i_axi_rresp  = AXI_RESP_OKAY;
        tick();
        bus.i_axi_rvalid = 1'b0;
        checks++; if (bus.o_wb_ack !== 1'b1 || bus.o_wb_data !== d) begin failures++; $display("FAIL fill_first_ack got=%0b/%0h exp=1/%0h", bus.o_wb_ack, bus.o_wb_data, d); end
        checks++; if (bus.o_wb_stall !== 1'b0) begin failures++; $display("FAIL fill_unstall got=%0b exp=0", bus.o_wb_stall); end
        tick();
        bus.i_wb_stb = 1'b0;
        checks++; if (bus.o_axi_arvalid !== 1'b1 || bus.o_axi_araddr !== ADDR_WIDTH'({addrs[8], 2'b00})) begin failures++; $display("FAIL fill_ar9 got=%0b/%0h exp=1/%0h", bus.o_axi_arvalid, bus.o_axi_araddr, {addrs[8], 2'b00}); end
        for (int k = 0; k < DEPTH; k++) begin
            d = $urandom;
            bus.i_axi_rvalid = 1'b1;
            bus.i_axi_rdata  = d;
            tick();
            checks++; if (bus.o_wb_ack !== 1'b1 || bus.o_wb_data !== d) begin failures++; $display("FAIL fill_drain%0d got=%0b/%0h exp=1/%0h", k, bus.o_wb_ack, bus.o_wb_data, d); end
        end
        bus.i_axi_rvalid = 1'b0;
        tick();
        checks++; if (bus.o_wb_ack !== 1'b0 || bus.o_wb_stall !== 1'b0) begin failures++; $display("FAIL fill_idle got=%0b/%0b exp=0/0", bus.o_wb_ack, bus.o_wb_stall); end
    endtask

    task automatic test_err_resp();
        logic [ADDR_WIDTH-1:0] araddr;
        logic ack, err, tail;
        logic [DW-1:0] data, d;
        single_read(AW'($urandom), $urandom, AXI_RESP_SLVERR, araddr, ack, err, data, tail);
        checks++; if (ack !== 1'b0 || err !== 1'b1 || tail !== 1'b0) begin failures++; $display("FAIL slverr got=%0b/%0b/%0b exp=0/1/0", ack, err, tail); end
        single_read(AW'($urandom), $urandom, AXI_RESP_DECERR, araddr, ack, err, data, tail);
        checks++; if (ack !== 1'b0 || err !== 1'b1 || tail !== 1'b0) begin failures++; $display("FAIL decerr got=%0b/%0b/%0b exp=0/1/0", ack, err, tail); end
        d = $urandom;
        single_read(AW'($urandom), d, AXI_RESP_OKAY, araddr, ack, err, data, tail);
        checks++; if (ack !== 1'b1 || err !== 1'b0 || data !== d) begin failures++; $display("FAIL after_err_ack got=%0b/%0b/%0h exp=1/0/%0h", ack, err, data, d); end
    endtask

    task automatic test_flush();
        logic [ADDR_WIDTH-1:0] araddr;
        logic ack, err, tail;
        logic [DW-1:0] data, d;
        do_reset();
        bus.i_wb_cyc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.i_wb_stb  = 1'b1;
            bus.i_wb_addr = AW'($urandom);
            tick();
        end
        bus.i_wb_stb = 1'b0;
        tick();
        bus.i_wb_cyc = 1'b0;
        tick();
        checks++; if (bus.o_wb_stall !== 1'b1) begin failures++; $display("FAIL flush_stall got=%0b exp=1", bus.o_wb_stall); end
        for (int k = 0; k < 3; k++) begin
            bus.i_axi_rvalid = 1'b1;
            bus.i_axi_rdata  = $urandom;
            bus.i_axi_rresp  = 2'($urandom_range(0, 3));
            tick();
            checks++; if (bus.o_wb_ack !== 1'b0 || bus.o_wb_err !== 1'b0) begin failures++; $display("FAIL flush_discard%0d got=%0b/%0b exp=0/0", k, bus.o_wb_ack, bus.o_wb_err); end
        end
        bus.i_axi_rvalid = 1'b0;
        tick();
        checks++; if (bus.o_wb_stall !== 1'b0) begin failures++; $display("FAIL flush_exit got=%0b exp=0", bus.o_wb_stall); end
        d = $urandom;
        single_read(AW'($urandom), d, AXI_RESP_OKAY, araddr, ack, err, data, tail);
        checks++; if (ack !== 1'b1 || data !== d) begin failures++; $display("FAIL flush_then_read got=%0b/%0h exp=1/%0h", ack, data, d); end
        // cyc drop coinciding with the only R beat
        bus.i_wb_cyc  = 1'b1;
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_addr = AW'($urandom);
        tick();
        bus.i_wb_stb = 1'b0;
        tick();
        bus.i_wb_cyc     = 1'b0;
        bus.i_axi_rvalid = 1'b1;
        bus.i_axi_rresp  = AXI_RESP_OKAY;
        tick();
        bus.i_axi_rvalid = 1'b0;
        checks++; if (bus.o_wb_ack !== 1'b0) begin failures++; $display("FAIL drop_beat_ack got=%0b exp=0", bus.o_wb_ack); end
        tick();
        checks++; if (bus.o_wb_stall !== 1'b0) begin failures++; $display("FAIL drop_beat_count got=%0b exp=0", bus.o_wb_stall); end
    endtask

    task automatic test_write_err();
        do_reset();
        bus.i_wb_cyc  = 1'b1;
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_we   = 1'b1;
        bus.i_wb_addr = AW'($urandom);
        #1;
        checks++; if (bus.o_wb_stall !== 1'b0) begin failures++; $display("FAIL wr_idle_stall got=%0b exp=0", bus.o_wb_stall); end
        tick();
        bus.i_wb_stb = 1'b0;
        checks++; if (bus.o_wb_err !== 1'b1 || bus.o_wb_ack !== 1'b0 || bus.o_axi_arvalid !== 1'b0) begin failures++; $display("FAIL wr_err got=%0b/%0b/%0b exp=1/0/0", bus.o_wb_err, bus.o_wb_ack, bus.o_axi_arvalid); end
        tick();
        checks++; if (bus.o_wb_err !== 1'b0 || bus.o_axi_arvalid !== 1'b0) begin failures++; $display("FAIL wr_err_pulse got=%0b/%0b exp=0/0", bus.o_wb_err, bus.o_axi_arvalid); end
        bus.i_wb_stb = 1'b1;
        bus.i_wb_we  = 1'b0;
        tick();
        bus.i_wb_we = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (bus.o_wb_stall !== 1'b1) begin failures++; $display("FAIL wr_busy_stall%0d got=%0b exp=1", c, bus.o_wb_stall); end
            tick();
        end
        bus.i_axi_rvalid = 1'b1;
        bus.i_axi_rresp  = AXI_RESP_OKAY;
        tick();
        bus.i_axi_rvalid = 1'b0;
        checks++; if (bus.o_wb_ack !== 1'b1 || bus.o_wb_stall !== 1'b0) begin failures++; $display("FAIL wr_after_drain got=%0b/%0b exp=1/0", bus.o_wb_ack, bus.o_wb_stall); end
        tick();
        bus.i_wb_stb = 1'b0;
        bus.i_wb_we  = 1'b0;
        checks++; if (bus.o_wb_err !== 1'b1) begin failures++; $display("FAIL wr_late_err got=%0b exp=1", bus.o_wb_err); end
        tick();
    endtask

    task automatic test_ar_hold_reset();
        logic [AW-1:0] a;
        logic [ADDR_WIDTH-1:0] exp_addr;
        do_reset();
        a = AW'($urandom);
        exp_addr = ADDR_WIDTH'({a, 2'b00});
        bus.i_axi_arready = 1'b0;
        bus.i_wb_cyc  = 1'b1;
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_addr = a;
        tick();
        bus.i_wb_addr = AW'($urandom);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (bus.o_axi_arvalid !== 1'b1 || bus.o_axi_araddr !== exp_addr || bus.o_wb_stall !== 1'b1) begin failures++; $display("FAIL ar_hold%0d got=%0b/%0h/%0b exp=1/%0h/1", c, bus.o_axi_arvalid, bus.o_axi_araddr, bus.o_wb_stall, exp_addr); end
            tick();
        end
        bus.i_wb_stb = 1'b0;
        w_reset = 1'b1;
        tick();
        checks++; if (bus.o_axi_arvalid !== 1'b0) begin failures++; $display("FAIL ar_reset got=%0b exp=0", bus.o_axi_arvalid); end
        w_reset = 1'b0;
        bus.i_axi_arready = 1'b1;
        bus.i_wb_stb = 1'b1;
        bus.i_wb_we  = 1'b1;
        #1;
        checks++; if (bus.o_wb_stall !== 1'b0) begin failures++; $display("FAIL ar_reset_outstanding got=%0b exp=0", bus.o_wb_stall); end
        bus.i_wb_stb = 1'b0;
        bus.i_wb_we  = 1'b0;
        tick();
    endtask

    task automatic test_random(input int ncycles);
        logic [ADDR_WIDTH-1:0] ar_q[$];
        logic [ADDR_WIDTH-1:0] rd_q[$];
        logic exp_ack = 1'b0, exp_err = 1'b0, werr_busy = 1'b0, next_werr, model_stall, draining;
        logic [DW-1:0] exp_data = '0;
        int n_acc = 0, n_resp = 0, cnt;
        do_reset();
        bus.i_wb_cyc = 1'b1;
        for (int c = 0; c < ncycles + 300; c++) begin
            draining = (c >= ncycles);
            checks++; if (bus.o_wb_ack !== exp_ack || bus.o_wb_err !== exp_err) begin failures++; $display("FAIL rnd_resp c=%0d got=%0b/%0b exp=%0b/%0b", c, bus.o_wb_ack, bus.o_wb_err, exp_ack, exp_err); end
            if (exp_ack) begin
                checks++; if (bus.o_wb_data !== exp_data) begin failures++; $display("FAIL rnd_data c=%0d got=%0h exp=%0h", c, bus.o_wb_data, exp_data); end
            end
            checks++; if (bus.o_axi_arvalid !== (ar_q.size() != 0)) begin failures++; $display("FAIL rnd_arvalid c=%0d got=%0b exp=%0b", c, bus.o_axi_arvalid, ar_q.size() != 0); end
            if (ar_q.size() != 0) begin
                checks++; if (bus.o_axi_araddr !== ar_q[0]) begin failures++; $display("FAIL rnd_araddr c=%0d got=%0h exp=%0h", c, bus.o_axi_araddr, ar_q[0]); end
            end
            if (draining && ar_q.size() == 0 && rd_q.size() == 0 && !werr_busy && !exp_ack && !exp_err) break;

            bus.i_wb_stb      = !draining && ($urandom_range(0, 3) != 0);
            bus.i_wb_we       = bus.i_wb_stb && ($urandom_range(0, 9) == 0);
            bus.i_wb_addr     = AW'($urandom);
            bus.i_axi_arready = draining || ($urandom_range(0, 2) != 0);
            bus.i_axi_rvalid  = (rd_q.size() != 0) && (draining || ($urandom_range(0, 1) == 1));
            bus.i_axi_rdata   = $urandom;
            bus.i_axi_rresp   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            #1;
            cnt = ar_q.size() + rd_q.size();
            model_stall = werr_busy || (cnt == DEPTH) || ((ar_q.size() != 0) && !bus.i_axi_arready)
                       || (bus.i_wb_we && (cnt != 0));
            checks++; if (bus.o_wb_stall !== model_stall) begin failures++; $display("FAIL rnd_stall c=%0d got=%0b exp=%0b", c, bus.o_wb_stall, model_stall); end

            exp_ack   = 1'b0;
            exp_err   = 1'b0;
            next_werr = 1'b0;
            if (bus.i_axi_rvalid) begin
                void'(rd_q.pop_front());
                exp_ack  = !bus.i_axi_rresp[1];
                exp_err  = bus.i_axi_rresp[1];
                exp_data = bus.i_axi_rdata;
                n_resp++;
            end
            if ((ar_q.size() != 0) && bus.i_axi_arready) rd_q.push_back(ar_q.pop_front());
            if (bus.i_wb_stb && !model_stall) begin
                if (bus.i_wb_we) begin
                    exp_err   = 1'b1;
                    next_werr = 1'b1;
                end else begin
                    ar_q.push_back(ADDR_WIDTH'({bus.i_wb_addr, 2'b00}));
                    n_acc++;
                end
            end
            werr_busy = next_werr;
            tick();
        end
        checks++; if (n_resp !== n_acc || ar_q.size() != 0 || rd_q.size() != 0) begin failures++; $display("FAIL rnd_balance got=%0d/%0d exp equal and drained", n_resp, n_acc); end
        idle_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_fill_stall();
        test_err_resp();
        test_flush();
        test_write_err();
        test_ar_hold_reset();
        test_random(800);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
